// File: rtl/count_checker.sv
// count_checker
// Watches the 8-bit count stream from the free-running counter and checks that
// each qualified sample is the previous sample plus one (mod 256). It locks onto
// the sequence, pulses on breaks while locked, and keeps saturating error and
// wrap statistics.
module count_checker #(
  parameter int LOCK_CYCLES = 4,
  parameter int ERR_WIDTH   = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [7:0]           count_in,
  input  logic                 count_valid,
  input  logic                 clear_err,
  output logic                 locked,
  output logic                 error_pulse,
  output logic [ERR_WIDTH-1:0] err_count,
  output logic [ERR_WIDTH-1:0] wrap_count,
  output logic [7:0]           expected
);

  typedef enum logic [1:0] {
    FIRST  = 2'd0,
    SEARCH = 2'd1,
    LOCKED = 2'd2
  } state_t;

  // good_run is only four bits wide, so the match target is compared in five
  // bits to keep the increment from overflowing at the top of the range.
  localparam logic [4:0]           LOCK_TARGET = 5'(LOCK_CYCLES);
  localparam logic [ERR_WIDTH-1:0] CNT_MAX     = '1;
  localparam logic [ERR_WIDTH-1:0] CNT_ONE     = {{(ERR_WIDTH-1){1'b0}}, 1'b1};

  state_t      state;
  logic [3:0]  good_run;
  logic        sample_match;
  logic        err_event;
  logic        wrap_pulse;
  logic [4:0]  run_next;
  logic [7:0]  next_expected;

  // Clear takes priority over the current value, then the increment is
  // applied on top, so a clear coincident with an event leaves the count at 1.
  function automatic logic [ERR_WIDTH-1:0] bump(
    input logic [ERR_WIDTH-1:0] cur,
    input logic                 clr,
    input logic                 inc
  );
    logic [ERR_WIDTH-1:0] base;
    base = clr ? '0 : cur;
    if (inc && (base != CNT_MAX)) begin
      bump = base + CNT_ONE;
    end else begin
      bump = base;
    end
  endfunction

  // Classify the current sample against the sequence being tracked.
  always_comb begin
    sample_match  = (count_in == expected);
    err_event     = count_valid && (state == LOCKED) && !sample_match;
    wrap_pulse    = count_valid && (state == LOCKED) && sample_match && (count_in == 8'd0);
    run_next      = {1'b0, good_run} + 5'd1;
    next_expected = count_in + 8'd1;
  end

  // Sequence tracker: state, run length, expected value and the registered
  // lock / error flags all move together on qualified samples only.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= FIRST;
      good_run    <= 4'd0;
      expected    <= 8'd0;
      locked      <= 1'b0;
      error_pulse <= 1'b0;
    end else begin
      error_pulse <= 1'b0;
      if (count_valid) begin
        expected <= next_expected;
        unique case (state)
          FIRST: begin
            good_run <= 4'd0;
            state    <= SEARCH;
          end
          SEARCH: begin
            if (sample_match) begin
              good_run <= run_next[3:0];
              if (run_next == LOCK_TARGET) begin
                state  <= LOCKED;
                locked <= 1'b1;
              end
            end else begin
              good_run <= 4'd0;
            end
          end
          LOCKED: begin
            if (!sample_match) begin
              error_pulse <= 1'b1;
              locked      <= 1'b0;
              good_run    <= 4'd0;
              state       <= SEARCH;
            end
          end
          default: begin
            state    <= FIRST;
            good_run <= 4'd0;
            locked   <= 1'b0;
          end
        endcase
      end
    end
  end

  // Saturating statistics; clear_err acts on every cycle, qualified or not.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_count  <= '0;
      wrap_count <= '0;
    end else begin
      err_count  <= bump(err_count, clear_err, err_event);
      wrap_count <= bump(wrap_count, clear_err, wrap_pulse);
    end
  end

endmodule

// File: tb/tb_count_checker.sv
// tb_count_checker
// Drives directed and random count streams into count_checker and compares
// every cycle against a history-based reference model.
module tb_count_checker;

  localparam int LOCK_CYCLES = 4;
  localparam int ERR_WIDTH   = 4;
  localparam int SAT         = (1 << ERR_WIDTH) - 1;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic [7:0]           countIn = 8'd0;
  logic                 countValid = 1'b0;
  logic                 clearErr = 1'b0;
  logic                 locked;
  logic                 errorPulse;
  logic [ERR_WIDTH-1:0] errCount;
  logic [ERR_WIDTH-1:0] wrapCount;
  logic [7:0]           expectedOut;

  int vectors = 0;
  int miscompares = 0;
  bit checkEn = 1'b0;

  // Reference model state: the history of valid samples since reset.
  int hist[$];
  int mErr = 0;
  int mWrap = 0;
  bit mLocked = 1'b0;
  bit mPulse = 1'b0;
  int mExpected = 0;

  count_checker #(
    .LOCK_CYCLES(LOCK_CYCLES),
    .ERR_WIDTH  (ERR_WIDTH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .count_in   (countIn),
    .count_valid(countValid),
    .clear_err  (clearErr),
    .locked     (locked),
    .error_pulse(errorPulse),
    .err_count  (errCount),
    .wrap_count (wrapCount),
    .expected   (expectedOut)
  );

  always #5 clk = ~clk;

  // Length of the trailing run of consecutive (+1 mod 256) samples.
  function automatic int runLen();
    int n;
    if (hist.size() == 0) return 0;
    n = 1;
    for (int i = hist.size() - 1; i > 0; i--) begin
      if (hist[i] == ((hist[i-1] + 1) % 256)) n++;
      else break;
    end
    return n;
  endfunction

  function automatic int satInc(input int v, input bit clr, input bit inc);
    int b;
    b = clr ? 0 : v;
    if (inc && b < SAT) b = b + 1;
    return b;
  endfunction

  // Model: locked means the newest run is at least LOCK_CYCLES+1 samples long.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      hist.delete();
      mErr = 0;
      mWrap = 0;
      mLocked = 1'b0;
      mPulse = 1'b0;
      mExpected = 0;
    end else begin
      bit wasLocked;
      bit isMatch;
      int s;
      mPulse = 1'b0;
      if (countValid) begin
        s = int'(countIn);
        wasLocked = runLen() >= LOCK_CYCLES + 1;
        isMatch = (hist.size() > 0) && (s == ((hist[hist.size()-1] + 1) % 256));
        hist.push_back(s);
        if (hist.size() > 40) void'(hist.pop_front());
        mPulse = wasLocked && !isMatch;
        mErr = satInc(mErr, clearErr, mPulse);
        mWrap = satInc(mWrap, clearErr, wasLocked && isMatch && (s == 0));
        mLocked = runLen() >= LOCK_CYCLES + 1;
        mExpected = (s + 1) % 256;
      end else begin
        mErr = satInc(mErr, clearErr, 1'b0);
        mWrap = satInc(mWrap, clearErr, 1'b0);
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, required %0d at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle: drive after the falling edge, return just after the sampling edge.
  task automatic applyStimulus(input bit v, input logic [7:0] s, input bit clr);
    @(negedge clk);
    #1;
    countValid = v;
    countIn = s;
    clearErr = clr;
    @(posedge clk);
    #1;
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("locked", 32'(locked), 32'(mLocked));
      checkOutput("error_pulse", 32'(errorPulse), 32'(mPulse));
      checkOutput("err_count", 32'(errCount), 32'(mErr));
      checkOutput("wrap_count", 32'(wrapCount), 32'(mWrap));
      checkOutput("expected", 32'(expectedOut), 32'(mExpected));
    end
  end

  initial begin
    int nextVal;
    int base;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_locked", 32'(locked), 0);
    checkOutput("rst_pulse", 32'(errorPulse), 0);
    checkOutput("rst_err", 32'(errCount), 0);
    checkOutput("rst_wrap", 32'(wrapCount), 0);
    checkOutput("rst_expected", 32'(expectedOut), 0);
    @(negedge clk);
    reset = 1'b0;
    checkEn = 1'b1;

    // Lock-up from a clean 0,1,2,... stream
    for (int v = 0; v <= 4; v++) begin
      applyStimulus(1'b1, 8'(v), 1'b0);
      if (v == 3) checkOutput("lock_early", 32'(locked), 0);
    end
    checkOutput("lock_rise", 32'(locked), 1);
    checkOutput("lock_err", 32'(errCount), 0);
    checkOutput("lock_expected", 32'(expectedOut), 5);
    checkOutput("model_lock", 32'(mLocked), 1);
    for (int v = 5; v <= 10; v++) applyStimulus(1'b1, 8'(v), 1'b0);
    checkOutput("pre_disc_expected", 32'(expectedOut), 11);

    // Discontinuity while locked
    applyStimulus(1'b1, 8'd13, 1'b0);
    checkOutput("disc_pulse", 32'(errorPulse), 1);
    checkOutput("disc_err", 32'(errCount), 1);
    checkOutput("disc_locked", 32'(locked), 0);
    checkOutput("disc_expected", 32'(expectedOut), 14);
    checkOutput("model_disc_err", 32'(mErr), 1);
    applyStimulus(1'b1, 8'd14, 1'b0);
    checkOutput("disc_pulse_once", 32'(errorPulse), 0);
    applyStimulus(1'b1, 8'd15, 1'b0);
    applyStimulus(1'b1, 8'd16, 1'b0);
    checkOutput("relock_early", 32'(locked), 0);
    applyStimulus(1'b1, 8'd17, 1'b0);
    checkOutput("relock", 32'(locked), 1);

    // Valid gaps with garbage on the bus
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 8'($urandom_range(0, 255)), 1'b0);
      checkOutput("gap_expected", 32'(expectedOut), 18);
      checkOutput("gap_locked", 32'(locked), 1);
      checkOutput("gap_pulse", 32'(errorPulse), 0);
    end
    applyStimulus(1'b1, 8'd18, 1'b0);
    checkOutput("gap_resume", 32'(locked), 1);

    // Wrap through 255 -> 0 while locked
    for (int v = 19; v <= 257; v++) begin
      applyStimulus(1'b1, 8'(v), 1'b0);
      if (v == 255) checkOutput("wrap_before", 32'(wrapCount), 0);
      if (v == 256) checkOutput("wrap_after", 32'(wrapCount), 1);
    end
    checkOutput("wrap_locked", 32'(locked), 1);
    checkOutput("wrap_no_err", 32'(errCount), 1);

    // Randomized stream: mostly in sequence, with breaks, gaps and clears
    nextVal = 2;
    for (int i = 0; i < 2000; i++) begin
      bit v;
      int s;
      v = ($urandom_range(0, 3) != 0);
      s = ($urandom_range(0, 9) != 0) ? nextVal : int'($urandom_range(0, 255));
      applyStimulus(v, 8'(s), ($urandom_range(0, 31) == 0));
      if (v) nextVal = (s + 1) % 256;
    end

    // Saturation and clear
    applyStimulus(1'b0, 8'hAA, 1'b1);
    checkOutput("clear_err_idle", 32'(errCount), 0);
    checkOutput("clear_wrap_idle", 32'(wrapCount), 0);
    for (int i = 0; i < 20; i++) begin
      base = (i * 16) % 256;
      for (int k = 0; k < 5; k++) applyStimulus(1'b1, 8'(base + k), 1'b0);
    end
    checkOutput("sat_err", 32'(errCount), SAT);
    checkOutput("model_sat_err", 32'(mErr), SAT);
    checkOutput("sat_locked", 32'(locked), 1);
    applyStimulus(1'b1, 8'd200, 1'b1);
    checkOutput("clear_with_inc", 32'(errCount), 1);
    checkOutput("clear_with_inc_pulse", 32'(errorPulse), 1);
    for (int v = 201; v <= 204; v++) applyStimulus(1'b1, 8'(v), 1'b0);
    checkOutput("sat_relock", 32'(locked), 1);
    applyStimulus(1'b0, 8'd0, 1'b1);
    checkOutput("clear_alone", 32'(errCount), 0);

    // Asynchronous reset mid-lock, between edges
    #2;
    reset = 1'b1;
    #1;
    checkOutput("areset_locked", 32'(locked), 0);
    checkOutput("areset_err", 32'(errCount), 0);
    checkOutput("areset_wrap", 32'(wrapCount), 0);
    checkOutput("areset_expected", 32'(expectedOut), 0);
    checkOutput("areset_pulse", 32'(errorPulse), 0);
    @(negedge clk);
    reset = 1'b0;
    applyStimulus(1'b1, 8'd77, 1'b0);
    checkOutput("post_reset_pulse", 32'(errorPulse), 0);
    checkOutput("post_reset_err", 32'(errCount), 0);
    checkOutput("post_reset_expected", 32'(expectedOut), 78);
    for (int v = 78; v <= 81; v++) applyStimulus(1'b1, 8'(v), 1'b0);
    checkOutput("post_reset_lock", 32'(locked), 1);

    @(negedge clk);
    checkEn = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/count_checker.md
# count_checker

Stream checker for the 8-bit free-running counter: consumes the `count` bus that the counter module produces, and verifies that each qualified sample is the previous sample plus one, modulo 256. It locks onto the sequence, flags discontinuities, and keeps saturating error and wrap statistics. It sits on the consuming side of the counter interface, either in the DUT wrapper next to the counter or as a standalone block driven from MyHDL.

## Interface
- `LOCK_CYCLES`, 4: consecutive matching samples needed to declare lock; range 1..15.
- `ERR_WIDTH`, 16: width of `err_count` and `wrap_count`; range 2..32.

- `clk`  in  1  single clock; everything samples on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `count_in`  in  8  counter value under check.
- `count_valid`  in  1  qualifies `count_in`; unqualified cycles are ignored entirely.
- `clear_err`  in  1  synchronous clear of `err_count` and `wrap_count`.
- `locked`  out  1  sequence is tracked and consistent.
- `error_pulse`  out  1  one-cycle pulse per discontinuity detected while locked.
- `err_count`  out  ERR_WIDTH  saturating count of discontinuities.
- `wrap_count`  out  ERR_WIDTH  saturating count of locked 255→0 transitions.
- `expected`  out  8  next value the checker expects.

## Operation
- State register values: FIRST, SEARCH, LOCKED. There is also a run counter `good_run` (4 bits).
- **FIRST** (reset state): on a valid sample `s`, set `expected`=s+1 mod 256 and `good_run`=0, then go to SEARCH. No error is raised.
- **SEARCH**: on a valid sample `s`:
  - If `s`==`expected`, increment `good_run`. When `good_run` reaches LOCK_CYCLES, go to LOCKED and assert `locked`.
  - If `s`≠`expected`, set `good_run`=0 and stay in SEARCH. No error is raised.
  - In both cases, `expected`=s+1.
- **LOCKED**: on a valid sample `s`:
  - If `s`==`expected`, stay in LOCKED. If `s`==0, increment `wrap_count` (saturating) and pulse `wrap_pulse` internally.
  - If `s`≠`expected`, assert `error_pulse`, increment `err_count` (saturating), clear `locked`, set `good_run`=0, and go to SEARCH.
  - In both cases, `expected`=s+1.
- `count_valid`=0: state, `expected`, `good_run` and both counters hold. `error_pulse` is 0.
- Counter arithmetic:
  - Saturation: both counters stop at 2^ERR_WIDTH−1 and never wrap.
  - `clear_err` with no simultaneous increment: the counter goes to 0.
  - `clear_err` in the same cycle as an increment: the counter result is 1, i.e. clear first, then increment.
  - `clear_err` does not affect state or `locked`.
- `expected` wraps 255+1→0 naturally with 8-bit arithmetic.

## Timing
- All outputs are registered. The response to a sample appears after the same rising edge that samples it, i.e. it is visible in the next cycle.
- Reset values: `locked`=0, `error_pulse`=0, `err_count`=0, `wrap_count`=0, `expected`=0, state FIRST, `good_run`=0.
- Assertion of `reset` clears all of the above immediately, without a clock edge, including mid-lock. The first valid sample after deassertion is treated as FIRST.
- `error_pulse` is high for exactly one cycle per mismatch. Back-to-back mismatches in LOCKED cannot occur, because the first mismatch exits to SEARCH.
- Lock latency from FIRST on a clean sequence is LOCK_CYCLES+1 valid samples. `locked` rises after the edge that samples the (LOCK_CYCLES+1)-th sample.
- Throughput is one sample per clock. There is no backpressure.

## Test plan
- **Lock-up.** Reset, then `count_in`=0,1,2,… with `count_valid`=1 and LOCK_CYCLES=4.
  - `locked` rises after the edge sampling 4.
  - `err_count`=0 and `expected`=5 in that cycle.
- **Wrap.** While locked, feed 253,254,255,0,1.
  - `wrap_count` goes 0→1 after the edge sampling 0.
  - `error_pulse` never asserts and `locked` stays 1.
- **Discontinuity.** While locked with `expected`=11, feed 13.
  - `error_pulse`=1 for one cycle, `err_count`=1, `locked`=0, `expected`=14.
  - Then feed 14,15,16,17: `locked` re-asserts after 17.
- **Valid gaps.** While locked, hold `count_valid`=0 for 3 cycles while `count_in` takes garbage values, then resume with the expected value.
  - No `error_pulse`, `locked` stays 1, and `expected` is unchanged across the gap.
- **Saturation and clear.** Use ERR_WIDTH=4 and force 20 lock/break cycles.
  - `err_count` holds at 15.
  - `clear_err` coincident with a mismatch gives `err_count`=1.
  - `clear_err` alone gives 0.
- **Asynchronous reset.** Assert `reset` mid-lock between clock edges.
  - `locked`, counters and `expected` read 0 before the next edge.
  - After release, the first valid sample causes no error.
